// File: rtl/ham_frame_tx_pkg.sv
// Shared Hamming(7,4) constants, FSM state encoding and the nibble encoding function
// used by the frame transmitter and its encoder sub-module.
package ham_pkg;

  localparam int HAM_CW_W    = 7;
  localparam int HAM_FRAME_W = 14;

  typedef logic [0:0] ham_state_t;
  localparam ham_state_t IDLE = 1'b0;
  localparam ham_state_t SEND = 1'b1;

  // Data bits occupy cw[6:3]; the three parity bits sit below them.
  function automatic logic [HAM_CW_W-1:0] ham74_cw(input logic [3:0] d);
    return {d, d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

endpackage

// File: rtl/ham_frame_tx_if.sv
// Bundles the PCM-side handshake and the FSK-side serial stream of the Hamming frame transmitter.
interface ham_frame_tx_if;

  logic       pcm_valid;
  logic [7:0] pcm_data;
  logic       pcm_ready;
  logic       tx_bit;
  logic       tx_valid;
  logic       tx_bit_stb;
  logic       frame_start;
  logic       frame_done;
  logic       busy;

  modport master (
    output pcm_valid, pcm_data,
    input  pcm_ready, tx_bit, tx_valid, tx_bit_stb, frame_start, frame_done, busy
  );

  modport slave (
    input  pcm_valid, pcm_data,
    output pcm_ready, tx_bit, tx_valid, tx_bit_stb, frame_start, frame_done, busy
  );

endinterface

// File: rtl/ham_frame_tx_enc.sv
// Purely combinational Hamming(7,4) encoder for a single nibble.
module ham74_enc
  import ham_pkg::*;
(
  input  logic [3:0]          nibble_i,
  output logic [HAM_CW_W-1:0] cw_o
);

  assign cw_o = ham74_cw(nibble_i);

endmodule

// File: rtl/ham_frame_tx.sv
// Hamming(7,4) frame transmitter: buffers one PCM sample, encodes both nibbles into a
// 14-bit frame and serializes it with BIT_DIV clocks per bit, back-to-back when possible.
module ham_frame_tx
  import ham_pkg::*;
#(
  parameter int BIT_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  ham_frame_tx_if.slave  bus
);

  localparam int                DIV_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [3:0]        LAST_BIT = 4'(HAM_FRAME_W - 1);

  ham_state_t             state_q, state_d;
  logic                   bufFull_q, bufFull_d;
  logic [7:0]             buf_q, buf_d;
  logic [HAM_FRAME_W-1:0] shreg_q, shreg_d;
  logic [3:0]             bitCnt_q, bitCnt_d;
  logic [DIV_W-1:0]       divCnt_q, divCnt_d;

  logic [HAM_CW_W-1:0]    cwHi, cwLo;
  logic [HAM_FRAME_W-1:0] frameEnc;
  logic                   pcmReady, accept, sending, divWrap, lastBit, frameDone, load;

  ham74_enc u_encHi (.nibble_i(buf_q[7:4]), .cw_o(cwHi));
  ham74_enc u_encLo (.nibble_i(buf_q[3:0]), .cw_o(cwLo));

  assign frameEnc = {cwHi, cwLo};

  assign pcmReady  = !bufFull_q && !rst;
  assign accept    = bus.pcm_valid && pcmReady;
  assign sending   = (state_q == SEND);
  assign divWrap   = (divCnt_q == DIV_LAST);
  assign lastBit   = (bitCnt_q == LAST_BIT);
  assign frameDone = sending && divWrap && lastBit;
  // A full buffer is drained either from IDLE or on the final edge of a frame, so the
  // next frame starts without an idle cycle; accept and load are mutually exclusive.
  assign load      = bufFull_q && ((state_q == IDLE) || frameDone);

  always_comb begin
    state_d   = state_q;
    bufFull_d = bufFull_q;
    buf_d     = buf_q;
    shreg_d   = shreg_q;
    bitCnt_d  = bitCnt_q;
    divCnt_d  = divCnt_q;

    if (accept) begin
      bufFull_d = 1'b1;
      buf_d     = bus.pcm_data;
    end

    if (sending) begin
      divCnt_d = divWrap ? '0 : divCnt_q + DIV_W'(1);
      if (divWrap) begin
        if (!lastBit) begin
          shreg_d  = MSB_FIRST ? {shreg_q[HAM_FRAME_W-2:0], 1'b0}
                               : {1'b0, shreg_q[HAM_FRAME_W-1:1]};
          bitCnt_d = bitCnt_q + 4'd1;
        end else if (!bufFull_q) begin
          state_d = IDLE;
        end
      end
    end

    if (load) begin
      state_d   = SEND;
      shreg_d   = frameEnc;
      bufFull_d = 1'b0;
      bitCnt_d  = '0;
      divCnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bufFull_q <= 1'b0;
      buf_q     <= '0;
      shreg_q   <= '0;
      bitCnt_q  <= '0;
      divCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bufFull_q <= bufFull_d;
      buf_q     <= buf_d;
      shreg_q   <= shreg_d;
      bitCnt_q  <= bitCnt_d;
      divCnt_q  <= divCnt_d;
    end
  end

  assign bus.pcm_ready   = pcmReady;
  assign bus.tx_valid    = sending;
  assign bus.tx_bit      = sending && (MSB_FIRST ? shreg_q[HAM_FRAME_W-1] : shreg_q[0]);
  assign bus.tx_bit_stb  = sending && (divCnt_q == '0);
  assign bus.frame_start = sending && (divCnt_q == '0) && (bitCnt_q == '0);
  assign bus.frame_done  = frameDone;
  assign bus.busy        = sending || bufFull_q;

endmodule

// File: tb/tb_ham_frame_tx.sv
// Scoreboard bench for ham_frame_tx: one instance at BIT_DIV=4 MSB-first, one at BIT_DIV=1 LSB-first.
module tb_ham_frame_tx;

  typedef struct {
    logic [13:0] frame;
    bit          gapless;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t qA[$];
  exp_t qB[$];

  int          bitIdxA = 0, bitIdxB = 0;
  int          startCycA = 0, startCycB = 0;
  int          lastDoneA = -10, lastDoneB = -10;
  int          expStartA = -1, expStartB = -1;
  int          doneCntA = 0, doneCntB = 0;
  logic [13:0] rxA = '0, rxB = '0;
  logic        curBitA = 1'b0, curBitB = 1'b0;

  ham_frame_tx_if ifA ();
  ham_frame_tx_if ifB ();

  ham_frame_tx #(.BIT_DIV(4), .MSB_FIRST(1'b1)) dutA (.clk(clk), .rst(rst), .bus(ifA));
  ham_frame_tx #(.BIT_DIV(1), .MSB_FIRST(1'b0)) dutB (.clk(clk), .rst(rst), .bus(ifB));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Independent reference: each parity bit is the XOR of the data bits it covers.
  function automatic logic [6:0] refCw(input logic [3:0] d);
    logic [3:0] m2, m1, m0;
    m2 = d & 4'b1110;
    m1 = d & 4'b1101;
    m0 = d & 4'b1011;
    return {d, ^m2, ^m1, ^m0};
  endfunction

  function automatic logic [13:0] modelFrame(input logic [7:0] s);
    return {refCw(s[7:4]), refCw(s[3:0])};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample frame A on the falling edge: collect bits, check timing and score frames.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bitIdxA = 0;
    end else begin
      if (ifA.frame_start) begin
        checkOutput("A.startReady", ifA.pcm_ready, 1);
        checkOutput("A.startIdx", bitIdxA, 0);
        if (qA.size() > 0 && qA[0].gapless) checkOutput("A.gapless", cyc, lastDoneA + 1);
        if (expStartA >= 0) begin
          checkOutput("A.latency", cyc, expStartA);
          expStartA = -1;
        end
        startCycA = cyc;
        rxA = '0;
      end
      if (ifA.tx_valid && ifA.tx_bit_stb) begin
        rxA = {rxA[12:0], ifA.tx_bit};
        curBitA = ifA.tx_bit;
        bitIdxA++;
      end else if (ifA.tx_valid) begin
        checkOutput("A.bitHold", ifA.tx_bit, curBitA);
      end
      if (ifA.frame_done) begin
        doneCntA++;
        checkOutput("A.bitCount", bitIdxA, 14);
        checkOutput("A.length", cyc - startCycA, 55);
        checkOutput("A.sbNonEmpty", qA.size() > 0, 1);
        if (qA.size() > 0) begin
          e = qA.pop_front();
          checkOutput("A.frame", rxA, e.frame);
        end
        lastDoneA = cyc;
        bitIdxA = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bitIdxB = 0;
    end else begin
      if (ifB.tx_valid) checkOutput("B.stbEvery", ifB.tx_bit_stb, 1);
      if (ifB.frame_start) begin
        checkOutput("B.startReady", ifB.pcm_ready, 1);
        checkOutput("B.startIdx", bitIdxB, 0);
        if (qB.size() > 0 && qB[0].gapless) checkOutput("B.gapless", cyc, lastDoneB + 1);
        if (expStartB >= 0) begin
          checkOutput("B.latency", cyc, expStartB);
          expStartB = -1;
        end
        startCycB = cyc;
        rxB = '0;
      end
      if (ifB.tx_valid && ifB.tx_bit_stb) begin
        rxB = {ifB.tx_bit, rxB[13:1]};
        curBitB = ifB.tx_bit;
        bitIdxB++;
      end
      if (ifB.frame_done) begin
        doneCntB++;
        checkOutput("B.bitCount", bitIdxB, 14);
        checkOutput("B.length", cyc - startCycB, 13);
        checkOutput("B.sbNonEmpty", qB.size() > 0, 1);
        if (qB.size() > 0) begin
          e = qB.pop_front();
          checkOutput("B.frame", rxB, e.frame);
        end
        lastDoneB = cyc;
        bitIdxB = 0;
      end
    end
  end

  // Offer one sample, wait (bounded) for acceptance and record the expected frame.
  task automatic applyStimulus(input bit useB, input logic [7:0] s, input logic [13:0] expFrame,
                               input bit gapless, input bit hold, input bit chkLat,
                               input bit expSending);
    int   waitCnt;
    logic rdy;
    exp_t e;
    @(negedge clk);
    if (useB) begin ifB.pcm_valid = 1'b1; ifB.pcm_data = s; end
    else      begin ifA.pcm_valid = 1'b1; ifA.pcm_data = s; end
    waitCnt = 0;
    rdy = useB ? ifB.pcm_ready : ifA.pcm_ready;
    while (!rdy && waitCnt < 400) begin
      @(negedge clk);
      waitCnt++;
      rdy = useB ? ifB.pcm_ready : ifA.pcm_ready;
    end
    checkOutput("acceptTimeout", rdy, 1);
    if (rdy) begin
      e.frame = expFrame;
      e.gapless = gapless;
      if (useB) qB.push_back(e); else qA.push_back(e);
      if (chkLat) begin
        if (useB) expStartB = cyc + 2; else expStartA = cyc + 2;
      end
      if (expSending) checkOutput("acceptDuringFrame", useB ? ifB.tx_valid : ifA.tx_valid, 1);
      @(posedge clk);
      #1;
      checkOutput("readyDrop", useB ? ifB.pcm_ready : ifA.pcm_ready, 0);
    end
    if (!hold || !rdy) begin
      if (useB) ifB.pcm_valid = 1'b0; else ifA.pcm_valid = 1'b0;
    end
  endtask

  task automatic waitIdle();
    int  n;
    bit  ok;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 5000) begin
      @(negedge clk);
      #1;
      ok = (qA.size() == 0) && (qB.size() == 0) && !ifA.busy && !ifB.busy;
      n++;
    end
    checkOutput("drainTimeout", ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int doneSnap;

    ifA.pcm_valid = 1'b0; ifA.pcm_data = '0;
    ifB.pcm_valid = 1'b0; ifB.pcm_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst.A.ready", ifA.pcm_ready, 0);
    checkOutput("rst.A.txValid", ifA.tx_valid, 0);
    checkOutput("rst.A.txBit", ifA.tx_bit, 0);
    checkOutput("rst.A.stb", ifA.tx_bit_stb, 0);
    checkOutput("rst.A.start", ifA.frame_start, 0);
    checkOutput("rst.A.done", ifA.frame_done, 0);
    checkOutput("rst.A.busy", ifA.busy, 0);
    checkOutput("rst.B.ready", ifB.pcm_ready, 0);
    checkOutput("rst.B.busy", ifB.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rel.A.ready", ifA.pcm_ready, 1);
    checkOutput("rel.B.ready", ifB.pcm_ready, 1);

    // Single frame, MSB first, latency from IDLE
    applyStimulus(1'b0, 8'hA5, 14'h292D, 1'b0, 1'b0, 1'b1, 1'b0);
    waitIdle();
    checkOutput("t1.doneCnt", doneCntA, 1);

    // Back-to-back frames with the second sample buffered during the first
    applyStimulus(1'b0, 8'h00, 14'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'hFF, 14'h3FFF, 1'b1, 1'b0, 1'b0, 1'b1);
    waitIdle();
    checkOutput("t2.doneCnt", doneCntA, 3);

    // Valid held high across three queued samples
    applyStimulus(1'b0, 8'h5A, modelFrame(8'h5A), 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h3C, modelFrame(8'h3C), 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h81, modelFrame(8'h81), 1'b1, 1'b0, 1'b0, 1'b1);
    waitIdle();
    checkOutput("t3.doneCnt", doneCntA, 6);

    // Reset mid-frame with the buffer full
    applyStimulus(1'b0, 8'h96, modelFrame(8'h96), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h69, modelFrame(8'h69), 1'b0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (bitIdxA != 7 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("t4.reachBit6", bitIdxA, 7);
    checkOutput("t4.bufFull", ifA.pcm_ready, 0);
    doneSnap = doneCntA;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t4.txValid", ifA.tx_valid, 0);
    checkOutput("t4.busy", ifA.busy, 0);
    checkOutput("t4.ready", ifA.pcm_ready, 0);
    checkOutput("t4.txBit", ifA.tx_bit, 0);
    checkOutput("t4.stb", ifA.tx_bit_stb, 0);
    checkOutput("t4.done", ifA.frame_done, 0);
    repeat (3) @(posedge clk);
    qA.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("t4.relReady", ifA.pcm_ready, 1);
    repeat (8) @(negedge clk);
    #1;
    checkOutput("t4.noResume", ifA.busy, 0);
    checkOutput("t4.noDone", doneCntA, doneSnap);

    // BIT_DIV=1, LSB first
    applyStimulus(1'b1, 8'hA5, 14'h292D, 1'b0, 1'b0, 1'b1, 1'b0);
    waitIdle();
    checkOutput("t5.doneCnt", doneCntB, 1);

    // Every sample value through the fast instance
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 8'(i), modelFrame(8'(i)), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    ifB.pcm_valid = 1'b0;
    waitIdle();
    checkOutput("t6.doneCnt", doneCntB, 257);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
